// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Fetch-stage controller. Owns the program counter, drives the
//               instruction memory address and captures the returned word
//               into the IF/ID pipeline register. Handles stall, flush,
//               branch/jump redirect and illegal fetch address detection.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Highest word-aligned address that can still be fetched in full.
  localparam logic [31:0] c_last_pc = 32'(IMEM_BYTES - 4);
  localparam logic [31:0] c_nop     = 32'h0000_0000;
  localparam logic [31:0] c_pc_step = 32'd4;

  // Two-state controller: RUN fetches, FAULT is absorbing until reset.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        r_fetch_fault;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic [31:0] w_ifid_pc4_nxt;
  logic        w_ifid_valid_nxt;
  logic        w_fetch_fault_nxt;
  logic [31:0] w_fetch_count_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_bad_pc;

  // Sequential fetch address; wraps at 2^32 and is caught by the range check.
  assign w_pc_plus4     = r_pc + c_pc_step;

  // A fetch is illegal if it is not word aligned or runs past the memory end.
  assign w_misaligned   = (r_pc[1:0] != 2'b00);
  assign w_out_of_range = (r_pc > c_last_pc);
  assign w_bad_pc       = w_misaligned | w_out_of_range;

  // Next-state and next-register computation; defaults hold everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ifid_instr_nxt  = r_ifid_instr;
    w_ifid_pc4_nxt    = r_ifid_pc4;
    w_ifid_valid_nxt  = r_ifid_valid;
    w_fetch_fault_nxt = r_fetch_fault;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      ST_RUN: begin
        if (w_bad_pc) begin
          // Illegal address: freeze PC, drop the slot, keep old IF/ID data.
          w_state_nxt       = ST_FAULT;
          w_fetch_fault_nxt = 1'b1;
          w_ifid_valid_nxt  = 1'b0;
        end else if (redirect_valid) begin
          // Taken branch/jump wins over stall and flush; squash wrong path.
          w_pc_nxt          = redirect_target;
          w_ifid_valid_nxt  = 1'b0;
          w_ifid_instr_nxt  = c_nop;
        end else if (stall && flush) begin
          // Decode holds, but its current slot must become a bubble.
          w_ifid_valid_nxt  = 1'b0;
          w_ifid_instr_nxt  = c_nop;
        end else if (stall) begin
          // Pure hazard stall: everything holds (defaults).
          w_pc_nxt          = r_pc;
        end else if (flush) begin
          // Advance past the current fetch but insert a bubble.
          w_pc_nxt          = w_pc_plus4;
          w_ifid_valid_nxt  = 1'b0;
          w_ifid_instr_nxt  = c_nop;
        end else begin
          // Normal fetch: latch the word and its link address.
          w_pc_nxt          = w_pc_plus4;
          w_ifid_instr_nxt  = instruction;
          w_ifid_pc4_nxt    = w_pc_plus4;
          w_ifid_valid_nxt  = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
        end
      end

      ST_FAULT: begin
        // Absorbing: only reset leaves; stall/flush/redirect are ignored.
        w_ifid_valid_nxt  = 1'b0;
        w_fetch_fault_nxt = 1'b1;
      end

      default: begin
        w_state_nxt       = ST_FAULT;
        w_ifid_valid_nxt  = 1'b0;
        w_fetch_fault_nxt = 1'b1;
      end
    endcase
  end

  // State and pipeline register update with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_ifid_instr  <= c_nop;
      r_ifid_pc4    <= 32'h0000_0000;
      r_ifid_valid  <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ifid_instr  <= w_ifid_instr_nxt;
      r_ifid_pc4    <= w_ifid_pc4_nxt;
      r_ifid_valid  <= w_ifid_valid_nxt;
      r_fetch_fault <= w_fetch_fault_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign pc          = r_pc;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_pc4    = r_ifid_pc4;
  assign ifid_valid  = r_ifid_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
